// File: rtl/am2950_pkg.sv
// am2950_pkg: shared constants for the am2950 registered bidirectional port.
// Holds the default data width and the reset value of the R/S data registers.
// Optional feature macro used by this design: AM2950_OVERRUN_EN.
package am2950_pkg;

    // Default width of both buses and both data registers.
    localparam int AM2950_WIDTH = 8;

    // Value loaded into R and S while rst is asserted.
    localparam logic [AM2950_WIDTH-1:0] AM2950_DATA_RST = '0;

endpackage : am2950_pkg

// File: rtl/am2950_chan.sv
// Purpose: one transfer channel of the am2950 (data register, full flag, load/ack priority).
// Latency: load and acknowledge both take effect at the next clk rising edge.
// Backpressure: none; the full flag is advisory, and a load always overwrites the register.
//
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   d         - data sampled into the register when ce_ is low
//   ce_       - active-low load enable (sets full)
//   ack_      - active-low acknowledge (clears full unless a load happens on the same edge)
//   q         - registered data
//   full      - word-waiting flag
//   ovr_evt   - combinational: a load is about to land on an unacknowledged word.
//               Only generated when AM2950_OVERRUN_EN is defined; constant 0 otherwise.
module am2950_chan
    import am2950_pkg::*;
#(
    parameter int WIDTH = AM2950_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             ce_,
    input  logic             ack_,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             ovr_evt
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             full_d;
    logic             full_q;

    // Load has priority over acknowledge so a word arriving in the
    // acknowledge cycle is never dropped.
    always_comb begin
        q_d    = q_q;
        full_d = full_q;
        if (!ce_) begin
            q_d    = d;
            full_d = 1'b1;
        end else if (!ack_) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= WIDTH'(AM2950_DATA_RST);
            full_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            full_q <= full_d;
        end
    end

    assign q    = q_q;
    assign full = full_q;

`ifdef AM2950_OVERRUN_EN
    // A load that coincides with an acknowledge is a clean hand-over, not an overrun.
    assign ovr_evt = !ce_ && full_q && ack_;
`else
    assign ovr_evt = 1'b0;
`endif

endmodule : am2950_chan

// File: rtl/am2950.sv
// Purpose: 8-bit bidirectional registered I/O port with R (A->B) and S (B->A) handshake flags.
// Latency: 1 clk from load/ack to register/flag; output enables to bus drive are combinational.
// Backpressure: none; fr/fs tell each side a word is waiting, loads always overwrite.
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   a, b         - bidirectional buses; a is sampled into R, b into S
//   cer_, ces_   - active-low load enables for R and S
//   ackr_, acks_ - active-low acknowledges clearing fr and fs
//   oea_, oeb_   - active-low output enables: a driven with S, b driven with R
//   fr, fs       - R full / S full flags
//   ovr          - sticky overrun flag when AM2950_OVERRUN_EN is defined, else tied 0
module am2950
    import am2950_pkg::*;
#(
    parameter int WIDTH = AM2950_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             cer_,
    input  logic             ces_,
    input  logic             ackr_,
    input  logic             acks_,
    input  logic             oea_,
    input  logic             oeb_,
    output logic             fr,
    output logic             fs,
    output logic             ovr
);

    logic [WIDTH-1:0] r_dat;
    logic [WIDTH-1:0] s_dat;
    logic             r_ovr_evt;
    logic             s_ovr_evt;

    // Channel R: captures side A, presented to side B.
    am2950_chan #(.WIDTH(WIDTH)) u_chan_r (
        .clk     (clk),
        .rst     (rst),
        .d       (a),
        .ce_     (cer_),
        .ack_    (ackr_),
        .q       (r_dat),
        .full    (fr),
        .ovr_evt (r_ovr_evt)
    );

    // Channel S: captures side B, presented to side A. With oeb_ low and
    // ces_ low this samples R off b, giving a deterministic loopback.
    am2950_chan #(.WIDTH(WIDTH)) u_chan_s (
        .clk     (clk),
        .rst     (rst),
        .d       (b),
        .ce_     (ces_),
        .ack_    (acks_),
        .q       (s_dat),
        .full    (fs),
        .ovr_evt (s_ovr_evt)
    );

    // Non-inverting tristate drivers; inversion belongs to the external transceivers.
    assign a = oea_ ? {WIDTH{1'bz}} : s_dat;
    assign b = oeb_ ? {WIDTH{1'bz}} : r_dat;

`ifdef AM2950_OVERRUN_EN
    logic ovr_d;
    logic ovr_q;

    // Sticky: only rst clears it.
    always_comb begin
        ovr_d = ovr_q | r_ovr_evt | s_ovr_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr = ovr_q;
`else
    // Both event inputs are constant 0 in this build, so ovr is tied low.
    assign ovr = r_ovr_evt | s_ovr_evt;
`endif

endmodule : am2950

// File: tb/tb_am2950.sv
// Directed self-checking bench for am2950. Expected values are hand-computed
// constants; overrun expectations follow AM2950_OVERRUN_EN.
module tb_am2950;

    logic       clk;
    logic       rst;
    logic       cer_;
    logic       ces_;
    logic       ackr_;
    logic       acks_;
    logic       oea_;
    logic       oeb_;
    logic       fr;
    logic       fs;
    logic       ovr;

    logic       a_en;
    logic       b_en;
    logic [7:0] a_drv;
    logic [7:0] b_drv;
    wire  [7:0] a;
    wire  [7:0] b;

    int checks;
    int failures;

`ifdef AM2950_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    assign a = a_en ? a_drv : 8'bz;
    assign b = b_en ? b_drv : 8'bz;

    am2950 dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .cer_  (cer_),
        .ces_  (ces_),
        .ackr_ (ackr_),
        .acks_ (acks_),
        .oea_  (oea_),
        .oeb_  (oeb_),
        .fr    (fr),
        .fs    (fs),
        .ovr   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        cer_  = 1'b1;
        ces_  = 1'b1;
        ackr_ = 1'b1;
        acks_ = 1'b1;
        oea_  = 1'b0;
        oeb_  = 1'b0;
        a_en  = 1'b0;
        b_en  = 1'b0;
        a_drv = 8'h00;
        b_drv = 8'h00;

        // Reset state with both outputs enabled.
        #2;
        check("rst_a",   a,   8'h00);
        check("rst_b",   b,   8'h00);
        check("rst_fr",  {7'd0, fr},  8'h00);
        check("rst_fs",  {7'd0, fs},  8'h00);
        check("rst_ovr", {7'd0, ovr}, 8'h00);
        #10;
        rst = 1'b0;

        // A->B transfer.
        oea_ = 1'b1; a_en = 1'b1; a_drv = 8'b10100101; cer_ = 1'b0;
        tick();
        cer_ = 1'b1;
        check("ab_b",  b, 8'b10100101);
        check("ab_fr", {7'd0, fr}, 8'h01);
        ackr_ = 1'b0;
        tick();
        ackr_ = 1'b1;
        check("ab_ack_fr", {7'd0, fr}, 8'h00);
        check("ab_ack_b",  b, 8'b10100101);

        // B->A transfer; a stays undriven by the DUT while oea_ is high, so
        // the bench's own pattern must read back untouched.
        oeb_ = 1'b1; b_en = 1'b1; b_drv = 8'b00111100; ces_ = 1'b0;
        a_drv = 8'h5A;
        tick();
        ces_ = 1'b1;
        check("ba_a_hiz", a, 8'h5A);
        check("ba_fs",    {7'd0, fs}, 8'h01);
        check("ba_fr_untouched", {7'd0, fr}, 8'h00);
        a_en = 1'b0; oea_ = 1'b0;
        #1;
        check("ba_a_drv", a, 8'b00111100);
        b_en = 1'b0; oeb_ = 1'b0;

        // Load and ack in the same cycle: load wins.
        oea_ = 1'b1; a_en = 1'b1; a_drv = 8'h11; cer_ = 1'b0;
        tick();
        check("la_pre_fr", {7'd0, fr}, 8'h01);
        a_drv = 8'b11110000; ackr_ = 1'b0;
        tick();
        cer_ = 1'b1; ackr_ = 1'b1;
        check("la_fr",  {7'd0, fr}, 8'h01);
        check("la_b",   b, 8'b11110000);
        check("la_ovr", {7'd0, ovr}, 8'h00);

        // Overrun: second load on a full R without ack.
        a_drv = 8'b00000001; cer_ = 1'b0;
        tick();
        cer_ = 1'b1;
        check("ovr_b",   b, 8'b00000001);
        check("ovr_set", {7'd0, ovr}, {7'd0, OVR_EXP});
        ackr_ = 1'b0;
        tick();
        ackr_ = 1'b1;
        check("ovr_ack_fr",  {7'd0, fr},  8'h00);
        check("ovr_sticky",  {7'd0, ovr}, {7'd0, OVR_EXP});

        // Acknowledge S, then acknowledge again while already empty.
        a_en = 1'b0; oea_ = 1'b0;
        acks_ = 1'b0;
        tick();
        check("acks_fs", {7'd0, fs}, 8'h00);
        tick();
        acks_ = 1'b1;
        check("acks_idle_fs", {7'd0, fs}, 8'h00);
        check("acks_idle_a",  a, 8'b00111100);

        // Independent simultaneous loads.
        oea_ = 1'b1; a_en = 1'b1; a_drv = 8'b01010101;
        oeb_ = 1'b1; b_en = 1'b1; b_drv = 8'b11001100;
        cer_ = 1'b0; ces_ = 1'b0;
        tick();
        cer_ = 1'b1; ces_ = 1'b1;
        check("ind_fr", {7'd0, fr}, 8'h01);
        check("ind_fs", {7'd0, fs}, 8'h01);
        a_en = 1'b0; b_en = 1'b0; oea_ = 1'b0; oeb_ = 1'b0;
        #1;
        check("ind_r", b, 8'b01010101);
        check("ind_s", a, 8'b11001100);

        // Loopback: S samples R off b.
        ces_ = 1'b0;
        tick();
        ces_ = 1'b1;
        check("loop_a", a, 8'b01010101);

        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        check("arst_a",   a,   8'h00);
        check("arst_b",   b,   8'h00);
        check("arst_fr",  {7'd0, fr},  8'h00);
        check("arst_fs",  {7'd0, fs},  8'h00);
        check("arst_ovr", {7'd0, ovr}, 8'h00);
        #1;
        rst = 1'b0;

        // First edge after reset follows the normal rules.
        oea_ = 1'b1; a_en = 1'b1; a_drv = 8'h09; cer_ = 1'b0;
        tick();
        cer_ = 1'b1; a_en = 1'b0;
        check("post_rst_b",   b, 8'h09);
        check("post_rst_fr",  {7'd0, fr},  8'h01);
        check("post_rst_ovr", {7'd0, ovr}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_am2950

// File: doc/am2950.md
# am2950

Eight-bit bidirectional registered I/O port with handshake flags, forming the clocked, flag-controlled other end of a bus fed by inverting tristate transceivers. Data written from side A is captured into the R register and presented to side B. Data written from side B is captured into the S register and presented to side A. Each direction has a "full" flag that is set on load and cleared by an acknowledge, so a CPU on one side and a peripheral on the other can exchange words without timing coupling.

## Interface
- WIDTH, 8, data width of both ports and both registers
- clk  input  1  rising-edge clock for all registers and flags
- rst  input  1  asynchronous, active-high reset
- a  inout  WIDTH  side-A bus; sampled into R; driven with S when oea_=0, else Z
- b  inout  WIDTH  side-B bus; sampled into S; driven with R when oeb_=0, else Z
- cer_  input  1  active-low load enable for R (A→B)
- ces_  input  1  active-low load enable for S (B→A)
- ackr_  input  1  active-low acknowledge, clears flag fr
- acks_  input  1  active-low acknowledge, clears flag fs
- oea_  input  1  active-low output enable for a
- oeb_  input  1  active-low output enable for b
- fr  output  1  R full: word waiting for side B
- fs  output  1  S full: word waiting for side A
- ovr  output  1  sticky overrun flag (only with AM2950_OVERRUN_EN; tied 0 otherwise)

## Operation
- Channel R, on the clk rising edge:
  - If cer_=0: R ← a and fr ← 1.
  - Else if ackr_=0: fr ← 0.
  - Else: hold.
- Channel S is identical, using ces_, b, S, acks_ and fs.
- Load and acknowledge in the same cycle: the load wins, so the flag ends at 1. The new word must not be lost.
- An acknowledge while the flag is already 0 has no effect.
- The two channels are fully independent. Simultaneous loads on R and S are legal.
- Output drivers are combinational:
  - a = oea_ ? Z : S
  - b = oeb_ ? Z : R
  - No inversion inside the block; inversion is the transceivers' job.
- Loopback: if oeb_=0 and ces_=0 in the same cycle, S captures the R value driven onto b at that edge. This is legal and deterministic.
- Bus contention: if oea_=0 while an external agent also drives a, the result is X. This is outside the block's responsibility and must not be tested as pass/fail.
- X or Z on a or b during a load is captured as-is.

## Timing
- Load latency: 1 clock. A word sampled at edge n appears on b/a after edge n, and fr/fs is 1 after edge n.
- Acknowledge latency: 1 clock. The flag drops after the edge on which ackr_/acks_ is sampled low.
- Output enable to drive and disable to Z: combinational, zero clocks.
- Reset values: R=0, S=0, fr=0, fs=0, ovr=0. a and b follow their oe_ pins (0 if enabled, Z if not).
- Reset is asynchronous. Asserting rst mid-transfer clears all state immediately, independent of clk.
- The first edge after rst deasserts obeys the normal rules.

## Configuration
- Macro: AM2950_OVERRUN_EN.
- Defined:
  - ovr is set at an edge where cer_=0 while fr=1 and ackr_=1, or where ces_=0 while fs=1 and acks_=1.
  - ovr is sticky and cleared only by rst.
  - A load that coincides with an acknowledge is not an overrun.
- Undefined: ovr is a constant 0, and no overrun logic is instantiated.

## Structure
- Package am2950_pkg holds:
  - the default width constant (8)
  - the reset value constant for the data registers (all zeros)
- Sub-module am2950_chan: one register, one flag and the load/ack priority logic.
  - Ports: clk, rst, d, ce_, ack_, q, full, ovr_evt.
  - Instantiated twice, once for R and once for S.
- Top level contains the tristate drivers and the optional ovr OR/sticky register.

## Test plan
- Reset: assert rst with oea_=oeb_=0 → a=00000000, b=00000000, fr=0, fs=0, ovr=0; assert rst asynchronously between edges → same, without waiting for clk.
- A→B transfer: a=10100101, cer_=0 for one edge, oeb_=0 → b=10100101, fr=1 after that edge; ackr_=0 for one edge → fr=0, b still 10100101.
- B→A transfer with tristate: b=00111100, ces_=0, oea_=1 → a=ZZZZZZZZ, fs=1; oea_=0 → a=00111100.
- Load and ack in the same cycle: fr=1, a=11110000, cer_=0, ackr_=0 → fr=1, b=11110000.
- Overrun (AM2950_OVERRUN_EN defined): fr=1, second load a=00000001 without ack → ovr=1, b=00000001; ack does not clear ovr; rst clears it. Without the macro → ovr stays 0.
- Independence: simultaneous cer_=0 (a=01010101) and ces_=0 (b=11001100, oeb_=1) → R=01010101, S=11001100, fr=fs=1.
